// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-ported 64-bit data memory between two requesters:
//   requester 0 - core load/store path
//   requester 1 - debug / DMA port
// Requests use a valid/ready handshake with round-robin priority. Each accepted
// transaction strobes MemRead or MemWrite for exactly one cycle and returns a
// one-cycle response pulse to its owner. Misaligned accesses never touch the
// memory and are answered with rsp_err.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata       request from requester N (stable until accepted)
//   reqN_ready                     combinational acceptance, only while idle
//   rspN_valid                     one-cycle response pulse to requester N
//   rsp_rdata, rsp_err             shared response payload, qualified by rspN_valid
//   MemRead, MemWrite, a, wd       registered memory pins
//   rd                             combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [DM_ADDRESS-1:0] req0_addr,
    input  logic [DATA_W-1:0]     req0_wdata,
    output logic                  req0_ready,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [DM_ADDRESS-1:0] req1_addr,
    input  logic [DATA_W-1:0]     req1_wdata,
    output logic                  req1_ready,

    output logic                  rsp0_valid,
    output logic                  rsp1_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,

    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [DM_ADDRESS-1:0] a,
    output logic [DATA_W-1:0]     wd,
    input  logic [DATA_W-1:0]     rd
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e                r_state;
    state_e                w_state_next;

    // Requester granted most recently; the other one wins the next contention.
    logic                  r_last_grant;
    logic                  r_owner;
    logic                  r_we;

    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [DM_ADDRESS-1:0] r_a;
    logic [DATA_W-1:0]     r_wd;

    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;
    logic                  r_rsp_err;
    logic [DATA_W-1:0]     r_rsp_rdata;

    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_sel;
    logic                  w_sel_we;
    logic [DM_ADDRESS-1:0] w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_aligned;

    // Arbitration: a lone requester always wins; under contention the one not
    // granted last time wins.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == StIdle) begin
            if (req0_valid && (!req1_valid || r_last_grant)) begin
                w_grant0 = 1'b1;
            end else if (req1_valid) begin
                w_grant1 = 1'b1;
            end
        end
    end

    assign w_accept    = w_grant0 | w_grant1;
    assign w_sel       = w_grant1;
    assign w_sel_we    = w_sel ? req1_we    : req0_we;
    assign w_sel_addr  = w_sel ? req1_addr  : req0_addr;
    assign w_sel_wdata = w_sel ? req1_wdata : req0_wdata;
    assign w_aligned   = (w_sel_addr[2:0] == 3'b000);

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_next = w_aligned ? StAcc : StResp;
                end
            end
            StAcc:   w_state_next = StResp;
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath and registered strobes. a/wd are loaded at acceptance so they are
    // already stable throughout the ACC cycle, and then simply hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_a          <= '0;
            r_wd         <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_rdata  <= '0;
        end else begin
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_owner      <= w_sel;
                        r_we         <= w_sel_we;
                        r_last_grant <= w_sel;
                        if (w_aligned) begin
                            r_mem_read  <= ~w_sel_we;
                            r_mem_write <= w_sel_we;
                            r_a         <= w_sel_addr;
                            if (w_sel_we) begin
                                r_wd <= w_sel_wdata;
                            end
                        end else begin
                            // Misaligned: answer straight away, memory untouched.
                            r_rsp0_valid <= ~w_sel;
                            r_rsp1_valid <= w_sel;
                            r_rsp_err    <= 1'b1;
                        end
                    end
                end
                StAcc: begin
                    if (!r_we) begin
                        r_rsp_rdata <= rd;
                    end
                    r_rsp0_valid <= ~r_owner;
                    r_rsp1_valid <= r_owner;
                    r_rsp_err    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign MemRead    = r_mem_read;
    assign MemWrite   = r_mem_write;
    assign a          = r_a;
    assign wd         = r_wd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed scenarios with literal expectations plus a randomized phase. A
// transaction-level reference model (timeline of expected strobe/response
// cycles and a word array) predicts every output on every cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [8:0]  req0_addr, req1_addr;
    logic [63:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid, rsp_err;
    logic [63:0] rsp_rdata;
    logic        MemRead, MemWrite;
    logic [8:0]  a;
    logic [63:0] wd;
    logic [63:0] rd;

    dmem_arbiter #(
        .DM_ADDRESS (9),
        .DATA_W     (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .a          (a),
        .wd         (wd),
        .rd         (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment memory: combinational read, write committed at the clock edge.
    logic [63:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [63:0] pl_data;

    assign rd = mem[a[8:3]];

    always @(posedge clk) begin
        if (MemWrite) begin
            mem[a[8:3]] <= wd;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] ref_mem [0:63];
    int          free_at;
    int          st_cyc;
    int          rp_cyc;
    logic        m_last;
    logic        st_we;
    logic [8:0]  st_addr;
    logic [63:0] st_wdata;
    logic        rp_owner, rp_err, rp_we;
    logic [63:0] rp_data;
    logic [8:0]  m_a;
    logic [63:0] m_wd, m_rdata;
    logic        m_err;

    always @(negedge clk) begin
        logic        e_mr, e_mw, e_v0, e_v1, e_r0, e_r1, acc, o, we;
        logic [8:0]  ad;
        logic [63:0] wdt;
        cyc = cyc + 1;
        if (!rst_n) begin
            free_at = 0;
            st_cyc  = -1;
            rp_cyc  = -1;
            m_last  = 1'b1;
            m_a     = '0;
            m_wd    = '0;
            m_rdata = '0;
            m_err   = 1'b0;
            if (pl_en) ref_mem[pl_idx] = pl_data;
            chk1("rst_memread", MemRead, 1'b0);
            chk1("rst_memwrite", MemWrite, 1'b0);
            chk1("rst_rsp0", rsp0_valid, 1'b0);
            chk1("rst_rsp1", rsp1_valid, 1'b0);
            chk1("rst_err", rsp_err, 1'b0);
            chk64("rst_rdata", rsp_rdata, 64'd0);
            chk64("rst_a", 64'(a), 64'd0);
            chk64("rst_wd", wd, 64'd0);
        end else begin
            e_mr = 1'b0; e_mw = 1'b0; e_v0 = 1'b0; e_v1 = 1'b0;
            e_r0 = 1'b0; e_r1 = 1'b0;
            if (st_cyc == cyc) begin
                e_mr = ~st_we;
                e_mw = st_we;
                m_a  = st_addr;
                if (st_we) m_wd = st_wdata;
                else       rp_data = ref_mem[st_addr[8:3]];
            end
            if (rp_cyc == cyc) begin
                e_v0  = ~rp_owner;
                e_v1  = rp_owner;
                m_err = rp_err;
                if (!rp_err && !rp_we) m_rdata = rp_data;
            end
            if (cyc >= free_at) begin
                if (req0_valid && (!req1_valid || m_last == 1'b1)) e_r0 = 1'b1;
                else if (req1_valid)                              e_r1 = 1'b1;
            end
            chk1("ready0", req0_ready, e_r0);
            chk1("ready1", req1_ready, e_r1);
            chk1("memread", MemRead, e_mr);
            chk1("memwrite", MemWrite, e_mw);
            chk1("mr_mw_exclusive", MemRead & MemWrite, 1'b0);
            chk64("a", 64'(a), 64'(m_a));
            chk64("wd", wd, m_wd);
            chk1("rsp0_valid", rsp0_valid, e_v0);
            chk1("rsp1_valid", rsp1_valid, e_v1);
            chk1("rsp_err", rsp_err, m_err);
            chk64("rsp_rdata", rsp_rdata, m_rdata);
            if (st_cyc == cyc && st_we) ref_mem[st_addr[8:3]] = st_wdata;

            acc = 1'b0; o = 1'b0; we = 1'b0; ad = '0; wdt = '0;
            if (e_r0) begin
                acc = 1'b1; o = 1'b0; we = req0_we; ad = req0_addr; wdt = req0_wdata;
            end else if (e_r1) begin
                acc = 1'b1; o = 1'b1; we = req1_we; ad = req1_addr; wdt = req1_wdata;
            end
            if (acc) begin
                m_last   = o;
                rp_owner = o;
                rp_we    = we;
                if (ad[2:0] == 3'b000) begin
                    st_cyc   = cyc + 1;
                    st_we    = we;
                    st_addr  = ad;
                    st_wdata = wdt;
                    rp_cyc   = cyc + 2;
                    rp_err   = 1'b0;
                    free_at  = cyc + 3;
                end else begin
                    rp_cyc  = cyc + 1;
                    rp_err  = 1'b1;
                    free_at = cyc + 2;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    int   gown [8];
    int   gcyc [8];
    int   ng;
    logic g0, g1, acc0, acc1;

    initial begin
        req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
        pl_en = 0; pl_idx = '0; pl_data = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        step();
        // Preload both memories while held in reset.
        pl_en = 1'b1;
        for (int i = 0; i < 64; i++) begin
            pl_idx  = 6'(i);
            pl_data = (i == 5) ? 64'hDEAD_BEEF_0000_0005 : {$urandom, $urandom};
            step();
        end
        pl_en = 1'b0;
        rst_n = 1'b1;

        // Single read of word 5.
        req0_valid = 1; req0_we = 0; req0_addr = 9'h028;
        neg(); chk1("t1_ready0", req0_ready, 1'b1);
        step(); req0_valid = 0;
        neg(); chk1("t1_memread", MemRead, 1'b1); chk64("t1_a", 64'(a), 64'h028);
        step();
        neg(); chk1("t1_rsp0", rsp0_valid, 1'b1);
        chk64("t1_rdata", rsp_rdata, 64'hDEAD_BEEF_0000_0005);
        chk1("t1_err", rsp_err, 1'b0);
        step();

        // Write then readback on requester 1.
        req1_valid = 1; req1_we = 1; req1_addr = 9'h100; req1_wdata = 64'h1234;
        neg(); chk1("t2_ready1", req1_ready, 1'b1);
        step(); req1_valid = 0;
        neg(); chk1("t2_memwrite", MemWrite, 1'b1); chk64("t2_wd", wd, 64'h1234);
        step();
        neg(); chk1("t2_memwrite_once", MemWrite, 1'b0);
        chk1("t2_rsp1", rsp1_valid, 1'b1); chk1("t2_err", rsp_err, 1'b0);
        step(); req1_valid = 1; req1_we = 0;
        neg(); chk1("t2_rd_ready1", req1_ready, 1'b1);
        step(); req1_valid = 0;
        neg(); chk1("t2_rd_memread", MemRead, 1'b1);
        step();
        neg(); chk1("t2_rd_rsp1", rsp1_valid, 1'b1); chk64("t2_rdata", rsp_rdata, 64'h1234);
        step();

        // Contention right after reset: 0,1,0,1,0,1 spaced 3 cycles apart.
        rst_n = 0; step(); step(); rst_n = 1;
        req0_valid = 1; req0_we = 0; req0_addr = 9'h008;
        req1_valid = 1; req1_we = 0; req1_addr = 9'h010;
        ng = 0;
        for (int c = 0; c < 20 && ng < 6; c++) begin
            neg();
            g0 = req0_ready; g1 = req1_ready;
            if (g0 && ng < 8) begin gown[ng] = 0; gcyc[ng] = c; ng++; end
            if (g1 && ng < 8) begin gown[ng] = 1; gcyc[ng] = c; ng++; end
            step();
            if (g0) req0_addr = req0_addr + 9'h040;
            if (g1) req1_addr = req1_addr + 9'h040;
        end
        req0_valid = 0; req1_valid = 0;
        chk64("t3_grants", 64'(ng), 64'd6);
        for (int i = 0; i < ng && i < 8; i++) begin
            chk64("t3_owner", 64'(gown[i]), 64'(i % 2));
            if (i > 0) chk64("t3_spacing", 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end
        step(); step(); step();

        // Misaligned read.
        req0_valid = 1; req0_we = 0; req0_addr = 9'h023;
        neg(); chk1("t4_ready0", req0_ready, 1'b1); chk1("t4_mr_c0", MemRead, 1'b0);
        step(); req0_valid = 0;
        neg(); chk1("t4_rsp0", rsp0_valid, 1'b1); chk1("t4_err", rsp_err, 1'b1);
        chk1("t4_mr_c1", MemRead, 1'b0); chk1("t4_mw_c1", MemWrite, 1'b0);
        step();
        neg(); chk1("t4_mr_c2", MemRead, 1'b0); chk1("t4_mw_c2", MemWrite, 1'b0);
        chk1("t4_rsp0_gone", rsp0_valid, 1'b0);
        step();

        // Reset during ACC of a requester-1 read.
        req1_valid = 1; req1_we = 0; req1_addr = 9'h0F0;
        neg(); chk1("t5_ready1", req1_ready, 1'b1);
        step(); req1_valid = 0;
        chk1("t5_memread_acc", MemRead, 1'b1);
        rst_n = 0;
        #1;
        chk1("t5_memread_async", MemRead, 1'b0);
        chk1("t5_rsp1_async", rsp1_valid, 1'b0);
        step(); rst_n = 1;
        repeat (3) begin
            neg(); chk1("t5_no_rsp1", rsp1_valid, 1'b0);
            step();
        end
        req0_valid = 1; req0_we = 0; req0_addr = 9'h048;
        req1_valid = 1; req1_we = 0; req1_addr = 9'h050;
        neg(); chk1("t5_first_ready0", req0_ready, 1'b1);
        chk1("t5_first_ready1", req1_ready, 1'b0);
        step(); req0_valid = 0; req1_valid = 0;
        step(); step(); step();

        // Requester 1 withdraws while requester 0 is in service.
        req0_valid = 1; req0_we = 0; req0_addr = 9'h030;
        neg(); chk1("t6_ready0", req0_ready, 1'b1);
        step(); req0_valid = 0; req1_valid = 1; req1_we = 0; req1_addr = 9'h038;
        neg(); chk1("t6_no_grant1_acc", req1_ready, 1'b0);
        step();
        neg(); chk1("t6_no_grant1_resp", req1_ready, 1'b0);
        step(); req1_valid = 0;
        repeat (3) begin
            neg(); chk1("t6_no_rsp1", rsp1_valid, 1'b0);
            step();
        end

        // Randomized traffic; the model checks every cycle.
        for (int c = 0; c < 3000; c++) begin
            neg();
            acc0 = req0_valid & req0_ready;
            acc1 = req1_valid & req1_ready;
            step();
            if (acc0 || (req0_valid && $urandom_range(0, 19) == 0)) begin
                req0_valid = 0;
            end else if (!req0_valid && $urandom_range(0, 2) == 0) begin
                req0_valid = 1;
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = {6'($urandom_range(0, 63)), 3'b000};
                if ($urandom_range(0, 7) == 0) req0_addr[2:0] = 3'($urandom_range(1, 7));
                req0_wdata = {$urandom, $urandom};
            end
            if (acc1 || (req1_valid && $urandom_range(0, 19) == 0)) begin
                req1_valid = 0;
            end else if (!req1_valid && $urandom_range(0, 2) == 0) begin
                req1_valid = 1;
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = {6'($urandom_range(0, 63)), 3'b000};
                if ($urandom_range(0, 7) == 0) req1_addr[2:0] = 3'($urandom_range(1, 7));
                req1_wdata = {$urandom, $urandom};
            end
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
